wb_imem_prefetch: RTL and testbench

WB_IMEM_PREFETCH -- requirements
Module: wb_imem_prefetch

---
 rtl/wb_imem_prefetch_if.sv | 42 ++++
 rtl/wb_imem_prefetch.sv | 131 +++++++++++++
 tb/tb_wb_imem_prefetch.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_imem_prefetch_if.sv
// Bus bundle for the fetch/data prefetch block: CPU fetch port, CPU data port
// and the single master port towards the QSPI memory controller.
interface wb_imem_prefetch_if;
  logic        imem_stb_i;
  logic [22:0] imem_adr_i;
  logic [31:0] imem_dat_o;
  logic        imem_ack_o;

  logic        dmem_stb_i;
  logic        dmem_we_i;
  logic [3:0]  dmem_be_i;
  logic [22:0] dmem_adr_i;
  logic [31:0] dmem_dat_i;
  logic [31:0] dmem_dat_o;
  logic        dmem_ack_o;

  logic        mem_stb_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [22:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;

  modport slave (
    input  imem_stb_i, imem_adr_i,
    output imem_dat_o, imem_ack_o,
    input  dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    output dmem_dat_o, dmem_ack_o,
    output mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o,
    input  mem_dat_i, mem_ack_i
  );

  modport master (
    output imem_stb_i, imem_adr_i,
    input  imem_dat_o, imem_ack_o,
    output dmem_stb_i, dmem_we_i, dmem_be_i, dmem_adr_i, dmem_dat_i,
    input  dmem_dat_o, dmem_ack_o,
    input  mem_stb_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o,
    output mem_dat_i, mem_ack_i
  );
endinterface

// File: rtl/wb_imem_prefetch.sv
// Arbiter between CPU fetch and data ports onto one memory master, with a
// one-word sequential instruction prefetch buffer.
module wb_imem_prefetch #(
  parameter bit PREFETCH = 1'b1
) (
  input logic               clk_i,
  input logic               rst_in,
  wb_imem_prefetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IFETCH, DACC, PFETCH} state_t;

  state_t      state, state_d;
  logic [22:0] adr_q, adr_d, done_adr;
  logic        pf_valid, pf_clr, pf_ld, imem_done;
  logic [22:0] pf_adr;
  logic [31:0] pf_dat;
  logic        hit_ack, hit_d;

  // The last word of a region is never followed by a prefetch.
  function automatic logic can_pf(input logic [22:0] a);
    return PREFETCH && (a[21:0] != '1);
  endfunction

  always_comb begin
    state_d        = state;
    adr_d          = adr_q;
    done_adr       = adr_q;
    hit_d          = 1'b0;
    pf_clr         = 1'b0;
    pf_ld          = 1'b0;
    imem_done      = 1'b0;
    bus.imem_ack_o = hit_ack;
    bus.imem_dat_o = hit_ack ? pf_dat : '0;
    bus.dmem_ack_o = 1'b0;
    bus.dmem_dat_o = '0;
    bus.mem_stb_o  = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_be_o   = '0;
    bus.mem_adr_o  = '0;
    bus.mem_dat_o  = '0;
    unique case (state)
      IDLE: begin
        // The cycle carrying a buffer-hit ack still sees the old strobe.
        if (!hit_ack) begin
          if (bus.dmem_stb_i) begin
            state_d = DACC;
          end else if (bus.imem_stb_i) begin
            if (pf_valid && (bus.imem_adr_i == pf_adr)) begin
              hit_d     = 1'b1;
              imem_done = 1'b1;
              done_adr  = bus.imem_adr_i;
            end else begin
              state_d = IFETCH;
              adr_d   = bus.imem_adr_i;
              pf_clr  = 1'b1;
            end
          end
        end
      end
      IFETCH: begin
        bus.mem_stb_o  = 1'b1;
        bus.mem_be_o   = 4'hF;
        bus.mem_adr_o  = adr_q;
        bus.imem_ack_o = bus.mem_ack_i;
        bus.imem_dat_o = bus.mem_dat_i;
        if (bus.mem_ack_i) begin
          state_d   = IDLE;
          imem_done = 1'b1;
        end
      end
      DACC: begin
        bus.mem_stb_o  = 1'b1;
        bus.mem_we_o   = bus.dmem_we_i;
        bus.mem_be_o   = bus.dmem_be_i;
        bus.mem_adr_o  = bus.dmem_adr_i;
        bus.mem_dat_o  = bus.dmem_dat_i;
        bus.dmem_ack_o = bus.mem_ack_i;
        bus.dmem_dat_o = bus.mem_dat_i;
        if (bus.mem_ack_i) begin
          state_d = IDLE;
          pf_clr  = bus.dmem_we_i;
        end
      end
      PFETCH: begin
        bus.mem_stb_o = 1'b1;
        bus.mem_be_o  = 4'hF;
        bus.mem_adr_o = adr_q;
        if (bus.mem_ack_i) begin
          pf_ld   = 1'b1;
          state_d = IDLE;
          // A fetch already waiting for this word is served straight from the bus.
          if (bus.imem_stb_i && (bus.imem_adr_i == adr_q)) begin
            bus.imem_ack_o = 1'b1;
            bus.imem_dat_o = bus.mem_dat_i;
            imem_done      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (imem_done && can_pf(done_adr)) begin
      state_d = PFETCH;
      adr_d   = {done_adr[22], done_adr[21:0] + 22'd1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      adr_q    <= '0;
      pf_valid <= 1'b0;
      pf_adr   <= '0;
      pf_dat   <= '0;
      hit_ack  <= 1'b0;
    end else begin
      adr_q   <= adr_d;
      hit_ack <= hit_d;
      if (pf_ld) begin
        pf_valid <= 1'b1;
        pf_adr   <= adr_q;
        pf_dat   <= bus.mem_dat_i;
      end else if (pf_clr) begin
        pf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_imem_prefetch.sv
// Self-checking bench for wb_imem_prefetch: directed scenarios followed by
// randomized fetch/data traffic against a transaction-level reference model.
module tb_wb_imem_prefetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_imem_prefetch_if bus ();
  wb_imem_prefetch #(.PREFETCH(1'b1)) dut (.clk_i(clk), .rst_in(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // memory controller model
  int   mem_lat = 3;
  int   rsp_cnt = 0;
  logic rsp_ack = 1'b0;
  logic spur_ack = 1'b0;
  assign bus.mem_ack_i = rsp_ack | spur_ack;

  logic [31:0] bus_mem [logic [22:0]];
  logic [31:0] ref_mem [logic [22:0]];
  logic [23:0] log_q [$];
  logic [23:0] exp_q [$];

  // reference model of the prefetch buffer
  logic        m_valid = 1'b0;
  logic [22:0] m_adr   = '0;

  function automatic logic [31:0] dflt(input logic [22:0] a);
    return 32'hC0DE_0000 ^ {a[7:0], 1'b0, a};
  endfunction

  function automatic logic [31:0] bus_rd(input logic [22:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int unsigned i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic can_pf(input logic [22:0] a);
    return a[21:0] != 22'h3FFFFF;
  endfunction

  function automatic logic [22:0] nxt(input logic [22:0] a);
    return {a[22], a[21:0] + 22'd1};
  endfunction

  initial begin
    bus.mem_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      rsp_ack = 1'b0;
      if (!rst_n || !bus.mem_stb_o) begin
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
        if (rsp_cnt >= mem_lat) begin
          rsp_cnt = 0;
          rsp_ack = 1'b1;
          log_q.push_back({bus.mem_we_o, bus.mem_adr_o});
          if (bus.mem_we_o) begin
            bus_mem[bus.mem_adr_o] = merge(bus_rd(bus.mem_adr_o), bus.mem_dat_o, bus.mem_be_o);
            bus.mem_dat_i = '0;
          end else begin
            bus.mem_dat_i = bus_rd(bus.mem_adr_o);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.imem_ack_o || bus.dmem_ack_o) begin
      tests++;
      assert ((bus.imem_ack_o & bus.dmem_ack_o) === 1'b0)
        else begin fails++; $error("FAIL dual_ack: both acks high, required at most one"); end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [22:0] a, output logic [31:0] d, output int lat);
    @(posedge clk); #1;
    bus.imem_stb_i = 1'b1;
    bus.imem_adr_i = a;
    lat = -1;
    d   = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.imem_ack_o) begin lat = i; d = bus.imem_dat_o; break; end
    end
    @(posedge clk); #1;
    bus.imem_stb_i = 1'b0;
    tests++;
    assert (lat >= 0) else begin fails++; $error("FAIL imem_timeout: no ack for adr %h", a); end
    @(negedge clk);
    tests++;
    assert (bus.imem_ack_o === 1'b0)
      else begin fails++; $error("FAIL imem_ack_width: ack=%b, required 0", bus.imem_ack_o); end
  endtask

  task automatic dacc(input logic we, input logic [3:0] be, input logic [22:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    bus.dmem_stb_i = 1'b1;
    bus.dmem_we_i  = we;
    bus.dmem_be_i  = be;
    bus.dmem_adr_i = a;
    bus.dmem_dat_i = wd;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.dmem_ack_o) begin lat = i; rd = bus.dmem_dat_o; break; end
    end
    @(posedge clk); #1;
    bus.dmem_stb_i = 1'b0;
    bus.dmem_we_i  = 1'b0;
    tests++;
    assert (lat >= 0) else begin fails++; $error("FAIL dmem_timeout: no ack for adr %h", a); end
    @(negedge clk);
    tests++;
    assert (bus.dmem_ack_o === 1'b0)
      else begin fails++; $error("FAIL dmem_ack_width: ack=%b, required 0", bus.dmem_ack_o); end
  endtask

  task automatic settle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(negedge clk);
      if (bus.mem_stb_o) quiet = 0;
      else quiet++;
    end
    tests++;
    assert (quiet >= 3) else begin fails++; $error("FAIL settle: mem_stb_o never went idle"); end
  endtask

  task automatic check_log(input string tag);
    settle();
    tests++;
    assert (log_q.size() === exp_q.size())
      else begin fails++; $error("FAIL %s_count: %0d transfers, required %0d", tag, log_q.size(), exp_q.size()); end
    if (log_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        tests++;
        assert (log_q[i] === exp_q[i])
          else begin fails++; $error("FAIL %s_xfer%0d: we/adr=%h, required %h", tag, i, log_q[i], exp_q[i]); end
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic fetch_chk(input logic [22:0] a, input logic chk_lat, input string tag);
    logic        hit;
    logic [31:0] d, e;
    int          lat;
    hit = m_valid && (m_adr == a);
    e   = ref_rd(a);
    if (!hit) begin exp_q.push_back({1'b0, a}); m_valid = 1'b0; end
    if (can_pf(a)) begin exp_q.push_back({1'b0, nxt(a)}); m_valid = 1'b1; m_adr = nxt(a); end
    fetch(a, d, lat);
    tests++;
    assert (d === e) else begin fails++; $error("FAIL %s_data: got %h, required %h", tag, d, e); end
    if (chk_lat) begin
      tests++;
      assert (lat === (hit ? 1 : mem_lat))
        else begin fails++; $error("FAIL %s_lat: got %0d, required %0d", tag, lat, hit ? 1 : mem_lat); end
    end
  endtask

  task automatic dacc_chk(input logic we, input logic [3:0] be, input logic [22:0] a,
                          input logic [31:0] wd, input logic chk_lat, input string tag);
    logic [31:0] rd, e;
    int          lat;
    e = ref_rd(a);
    exp_q.push_back({we, a});
    if (we) begin
      ref_mem[a] = merge(e, wd, be);
      m_valid    = 1'b0;
    end
    dacc(we, be, a, wd, rd, lat);
    if (!we) begin
      tests++;
      assert (rd === e) else begin fails++; $error("FAIL %s_data: got %h, required %h", tag, rd, e); end
    end
    if (chk_lat) begin
      tests++;
      assert (lat === mem_lat)
        else begin fails++; $error("FAIL %s_lat: got %0d, required %0d", tag, lat, mem_lat); end
    end
  endtask

  task automatic reset_chk(input string tag);
    tests++;
    assert ({bus.mem_stb_o, bus.mem_we_o, bus.mem_be_o, bus.mem_adr_o, bus.mem_dat_o} === '0)
      else begin fails++; $error("FAIL %s_mem: stb=%b adr=%h, required all zero", tag, bus.mem_stb_o, bus.mem_adr_o); end
    tests++;
    assert ({bus.imem_ack_o, bus.imem_dat_o, bus.dmem_ack_o, bus.dmem_dat_o} === '0)
      else begin fails++; $error("FAIL %s_cpu: iack=%b idat=%h dack=%b, required all zero", tag, bus.imem_ack_o, bus.imem_dat_o, bus.dmem_ack_o); end
  endtask

  initial begin
    logic [31:0] d1, d2, e1, e2;
    int          l1, l2, r;
    logic [22:0] a, last_a;
    logic        b22;

    bus.imem_stb_i = 1'b0;
    bus.imem_adr_i = '0;
    bus.dmem_stb_i = 1'b0;
    bus.dmem_we_i  = 1'b0;
    bus.dmem_be_i  = '0;
    bus.dmem_adr_i = '0;
    bus.dmem_dat_i = '0;

    repeat (3) @(negedge clk);
    reset_chk("rst_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first fetch misses, then prefetch of the next word
    mem_lat = 5;
    fetch_chk(23'h000000, 1'b1, "s_first");
    check_log("s_first_log");

    // buffer hit: one-cycle ack without a fetch access
    mem_lat = 3;
    fetch_chk(23'h000001, 1'b1, "s_hit");
    check_log("s_hit_log");

    // data write arriving during a prefetch waits, then invalidates the buffer
    mem_lat = 6;
    fetch_chk(23'h000002, 1'b1, "s_hit2");
    dacc_chk(1'b1, 4'hF, 23'h400010, 32'h1234_5678, 1'b0, "s_wr");
    check_log("s_wr_log");
    mem_lat = 3;
    fetch_chk(23'h000003, 1'b1, "s_after_wr");
    check_log("s_after_wr_log");

    // simultaneous requests: data port first
    e1 = ref_rd(23'h000002);
    e2 = ref_rd(23'h400000);
    exp_q.push_back({1'b0, 23'h400000});
    exp_q.push_back({1'b0, 23'h000002});
    exp_q.push_back({1'b0, 23'h000003});
    m_valid = 1'b1;
    m_adr   = 23'h000003;
    fork
      fetch(23'h000002, d1, l1);
      dacc(1'b0, 4'hF, 23'h400000, 32'h0, d2, l2);
    join
    tests++;
    assert (d1 === e1) else begin fails++; $error("FAIL s_both_idata: got %h, required %h", d1, e1); end
    tests++;
    assert (d2 === e2) else begin fails++; $error("FAIL s_both_ddata: got %h, required %h", d2, e2); end
    check_log("s_both_log");

    // end of region: no prefetch
    fetch_chk(23'h3FFFFF, 1'b1, "s_end_rom");
    check_log("s_end_rom_log");
    fetch_chk(23'h7FFFFF, 1'b1, "s_end_ram");
    check_log("s_end_ram_log");

    // fetch pending on the in-flight prefetch word
    mem_lat = 4;
    fetch_chk(23'h000010, 1'b1, "s_pend_a");
    fetch_chk(23'h000011, 1'b0, "s_pend_b");
    check_log("s_pend_log");

    // stray memory ack while idle
    mem_lat = 3;
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(negedge clk);
    tests++;
    assert ({bus.imem_ack_o, bus.dmem_ack_o, bus.mem_stb_o} === 3'b000)
      else begin fails++; $error("FAIL s_spur: iack/dack/stb=%b, required 000", {bus.imem_ack_o, bus.dmem_ack_o, bus.mem_stb_o}); end
    @(posedge clk); #1;
    spur_ack = 1'b0;
    check_log("s_spur_log");
    fetch_chk(23'h000020, 1'b1, "s_spur_fetch");
    check_log("s_spur_fetch_log");

    // reset with a valid buffer: following fetch of that word misses
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    reset_chk("rst_idle");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_valid = 1'b0;
    fetch_chk(23'h000021, 1'b1, "s_rst_miss");
    check_log("s_rst_miss_log");

    // reset in the middle of a fetch
    mem_lat = 50;
    @(posedge clk); #1;
    bus.imem_stb_i = 1'b1;
    bus.imem_adr_i = 23'h000040;
    repeat (3) @(negedge clk);
    tests++;
    assert (bus.mem_stb_o === 1'b1)
      else begin fails++; $error("FAIL s_midrst_busy: stb=%b, required 1", bus.mem_stb_o); end
    #1;
    rst_n = 1'b0;
    #1;
    reset_chk("rst_mid");
    bus.imem_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_valid = 1'b0;
    log_q.delete();
    exp_q.delete();
    mem_lat = 3;
    fetch_chk(23'h000040, 1'b1, "s_midrst_miss");
    check_log("s_midrst_log");

    // randomized traffic
    last_a = 23'h000040;
    for (int n = 0; n < 60; n++) begin
      mem_lat = $urandom_range(2, 4);
      r = $urandom_range(0, 99);
      b22 = 1'($urandom_range(0, 1));
      if (r < 75) begin
        if (r < 45)      a = nxt(last_a);
        else if (r < 55) a = last_a;
        else if (r < 65) a = {b22, 22'h3FFFFF - 22'($urandom_range(0, 2))};
        else             a = {b22, 22'($urandom_range(0, 15))};
        fetch_chk(a, 1'b1, "rnd_fetch");
        last_a = a;
      end else begin
        dacc_chk(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 {1'b1, 18'd0, 4'($urandom_range(0, 15))}, $urandom, 1'b1, "rnd_dacc");
      end
      check_log("rnd_log");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
